// File: rtl/cache_wb_buffer.sv
// cache_wb_buffer
//   Write-back buffer placed between the set-associative cache and the
//   memory bus.
//   - Evicted dirty lines are queued in a DEPTH-entry FIFO.
//   - Each queued line is drained as an NBEATS-beat write burst, with beat 0
//     at the lowest address.
//   - A lookup port lets a read-fill source pick up a line that is still
//     queued instead of reading stale memory.
//
//   Ports
//     Clk, Rst             clock (rising edge); asynchronous active-low reset
//     WrBackAddr/Data      evicted line address (offset ignored) and line data
//     WrBackAddrVal/Rdy    enqueue handshake
//     MemWrAddr/Data       byte address and data of the current burst beat
//     MemWrVal/Last/Rdy    beat handshake; Last marks the final beat of a line
//     LookupAddr/En        line probe request
//     LookupHit/Data       registered probe result, valid the cycle after En
//     Count/Empty/Full     registered occupancy
//
//   Build option
//     WB_COALESCE_EN  when defined, a write-back whose line matches a queued
//                     entry (other than a head that is already bursting)
//                     overwrites that entry in place instead of allocating,
//                     and is accepted even when the buffer is full.
module cache_wb_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_BITS  = 32,
  parameter int LINE_BYTES = 16,
  parameter int MEM_BITS   = 32
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [ADDR_BITS-1:0]      WrBackAddr,
  input  logic [LINE_BYTES*8-1:0]   WrBackData,
  input  logic                      WrBackAddrVal,
  output logic                      WrBackAddrRdy,
  output logic [ADDR_BITS-1:0]      MemWrAddr,
  output logic [MEM_BITS-1:0]       MemWrData,
  output logic                      MemWrVal,
  output logic                      MemWrLast,
  input  logic                      MemWrRdy,
  input  logic [ADDR_BITS-1:0]      LookupAddr,
  input  logic                      LookupEn,
  output logic                      LookupHit,
  output logic [LINE_BYTES*8-1:0]   LookupData,
  output logic [$clog2(DEPTH):0]    Count,
  output logic                      Empty,
  output logic                      Full
);

  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int NBEATS     = LINE_BITS / MEM_BITS;
  localparam int PW         = $clog2(DEPTH);
  localparam int BW         = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int BEAT_BYTES = MEM_BITS / 8;

  localparam logic [ADDR_BITS-1:0] OFF_MASK  = ADDR_BITS'(LINE_BYTES - 1);
  localparam logic [BW-1:0]        LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [PW:0]          DEPTH_C   = (PW + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  function automatic logic [ADDR_BITS-1:0] line_addr(input logic [ADDR_BITS-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  // Entry storage: addresses are stored line-aligned; data is never reset.
  logic [ADDR_BITS-1:0] r_addr [DEPTH];
  logic [LINE_BITS-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]     r_vld;

  logic [PW:0]          r_wptr;
  logic [PW:0]          r_rptr;
  logic [PW:0]          r_count;
  logic                 r_empty;
  logic                 r_full;
  state_t               r_state;
  logic [BW-1:0]        r_beat;
  logic                 r_lk_hit;
  logic [LINE_BITS-1:0] r_lk_data;

  logic [PW-1:0]        w_wr_idx;
  logic [PW-1:0]        w_rd_idx;
  logic [PW-1:0]        w_idx;
  logic [ADDR_BITS-1:0] w_wb_line;
  logic [ADDR_BITS-1:0] w_lk_line;
  logic                 w_lk_hit;
  logic [PW-1:0]        w_lk_idx;
  logic                 w_push;
  logic                 w_pop;
  logic [PW:0]          w_count_nxt;
  logic [ADDR_BITS-1:0] w_beat_off;
  logic [LINE_BITS-1:0] w_head_data;
`ifdef WB_COALESCE_EN
  logic                 w_co_hit;
  logic [PW-1:0]        w_co_idx;
  logic                 w_co_wr;
`endif

  assign w_wr_idx    = r_wptr[PW-1:0];
  assign w_rd_idx    = r_rptr[PW-1:0];
  assign w_wb_line   = line_addr(WrBackAddr);
  assign w_lk_line   = line_addr(LookupAddr);
  assign w_head_data = r_data[w_rd_idx];

  // Walk the entries oldest to youngest starting at the head, so the last
  // match found is the youngest one.
  always_comb begin
    w_idx    = '0;
    w_lk_hit = 1'b0;
    w_lk_idx = '0;
`ifdef WB_COALESCE_EN
    w_co_hit = 1'b0;
    w_co_idx = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = w_rd_idx + PW'(i);
      if (r_vld[w_idx] && (r_addr[w_idx] == w_lk_line)) begin
        w_lk_hit = 1'b1;
        w_lk_idx = w_idx;
      end
`ifdef WB_COALESCE_EN
      // A head that is already bursting must not change under the bus.
      if (r_vld[w_idx] && (r_addr[w_idx] == w_wb_line) &&
          !((i == 0) && (r_state == S_BURST))) begin
        w_co_hit = 1'b1;
        w_co_idx = w_idx;
      end
`endif
    end
  end

`ifdef WB_COALESCE_EN
  assign WrBackAddrRdy = Rst && (!r_full || w_co_hit);
  assign w_push        = WrBackAddrVal && WrBackAddrRdy && !w_co_hit;
  assign w_co_wr       = WrBackAddrVal && WrBackAddrRdy && w_co_hit;
`else
  assign WrBackAddrRdy = Rst && !r_full;
  assign w_push        = WrBackAddrVal && WrBackAddrRdy;
`endif

  assign w_pop = (r_state == S_BURST) && MemWrRdy && (r_beat == LAST_BEAT);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - 1'b1;
  end

  // Queue control: pointers, valid bits and occupancy.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_vld   <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_vld[w_wr_idx] <= 1'b1;
        r_wptr          <= r_wptr + 1'b1;
      end
      // Push and pop never share an index: a push needs a non-full buffer.
      if (w_pop) begin
        r_vld[w_rd_idx] <= 1'b0;
        r_rptr          <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == DEPTH_C);
    end
  end

  // Entry payload write (enqueue or in-place coalesce).
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_addr[w_wr_idx] <= w_wb_line;
      r_data[w_wr_idx] <= WrBackData;
    end
`ifdef WB_COALESCE_EN
    if (w_co_wr)
      r_data[w_co_idx] <= WrBackData;
`endif
  end

  // Drain FSM: back-to-back lines stay in BURST with no idle cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_empty) begin
            r_state <= S_BURST;
            r_beat  <= '0;
          end
        end
        S_BURST: begin
          if (MemWrRdy) begin
            if (r_beat == LAST_BEAT) begin
              r_beat <= '0;
              if (w_count_nxt == '0)
                r_state <= S_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_beat  <= '0;
        end
      endcase
    end
  end

  assign w_beat_off = ADDR_BITS'(r_beat) * ADDR_BITS'(BEAT_BYTES);
  assign MemWrVal   = (r_state == S_BURST);
  assign MemWrLast  = MemWrVal && (r_beat == LAST_BEAT);
  assign MemWrAddr  = MemWrVal ? (r_addr[w_rd_idx] + w_beat_off) : '0;
  assign MemWrData  = MemWrVal ? w_head_data[r_beat*MEM_BITS +: MEM_BITS] : '0;

  // Lookup result register: data holds its last value on a miss.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_lk_hit  <= 1'b0;
      r_lk_data <= '0;
    end else begin
      r_lk_hit <= LookupEn && w_lk_hit;
      if (LookupEn && w_lk_hit)
        r_lk_data <= r_data[w_lk_idx];
    end
  end

  assign LookupHit  = r_lk_hit;
  assign LookupData = r_lk_data;
  assign Count      = r_count;
  assign Empty      = r_empty;
  assign Full       = r_full;

endmodule

// File: tb/tb_cache_wb_buffer.sv
module tb_cache_wb_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int LB    = 16;
  localparam int MW    = 32;
  localparam int LW    = LB * 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clk;
  logic          Rst;
  logic [AW-1:0] WrBackAddr;
  logic [LW-1:0] WrBackData;
  logic          WrBackAddrVal;
  logic          WrBackAddrRdy;
  logic [AW-1:0] MemWrAddr;
  logic [MW-1:0] MemWrData;
  logic          MemWrVal;
  logic          MemWrLast;
  logic          MemWrRdy;
  logic [AW-1:0] LookupAddr;
  logic          LookupEn;
  logic          LookupHit;
  logic [LW-1:0] LookupData;
  logic [CW-1:0] Count;
  logic          Empty;
  logic          Full;

  cache_wb_buffer #(
    .DEPTH(DEPTH), .ADDR_BITS(AW), .LINE_BYTES(LB), .MEM_BITS(MW)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .WrBackAddr(WrBackAddr), .WrBackData(WrBackData),
    .WrBackAddrVal(WrBackAddrVal), .WrBackAddrRdy(WrBackAddrRdy),
    .MemWrAddr(MemWrAddr), .MemWrData(MemWrData), .MemWrVal(MemWrVal),
    .MemWrLast(MemWrLast), .MemWrRdy(MemWrRdy),
    .LookupAddr(LookupAddr), .LookupEn(LookupEn),
    .LookupHit(LookupHit), .LookupData(LookupData),
    .Count(Count), .Empty(Empty), .Full(Full)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
    logic          last;
  } beat_t;

  beat_t sb_q[$];
  int    tests = 0;
  int    fails = 0;
  beat_t mon_got;
  beat_t mon_exp;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Expected beats of one line: ascending addresses, beat 0 from the LSBs.
  task automatic push_line(input logic [AW-1:0] a, input logic [LW-1:0] d);
    beat_t b;
    for (int k = 0; k < LW / MW; k++) begin
      b.addr = (a & ~32'hF) + 32'(k * (MW / 8));
      b.data = d[k*MW +: MW];
      b.last = (k == LW / MW - 1);
      sb_q.push_back(b);
    end
  endtask

  // One-cycle write-back offer; exp_acc is the bench's own acceptance model.
  task automatic enq(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] d,
                     input bit exp_acc, input bit do_push);
    WrBackAddr    = a;
    WrBackData    = d;
    WrBackAddrVal = 1'b1;
    #1;
    check(tag, 192'(WrBackAddrRdy), 192'(exp_acc));
    if (exp_acc && do_push) push_line(a, d);
    step();
    WrBackAddrVal = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 192'(sb_q.size()), 192'(0));
    sb_q.delete();
  endtask

  // Bus monitor: every accepted beat must be the next expected one.
  always @(negedge Clk) begin
    if (Rst && MemWrVal && MemWrRdy) begin
      if (sb_q.size() == 0) begin
        check("beat_unexpected", 192'(MemWrVal), 192'(0));
      end else begin
        mon_got.addr = MemWrAddr;
        mon_got.data = MemWrData;
        mon_got.last = MemWrLast;
        mon_exp = sb_q.pop_front();
        check("beat", 192'(mon_got), 192'(mon_exp));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [LW-1:0] d1, da, db, dc, dd, dx, dy, dn;

  initial begin
    Rst = 1'b0; WrBackAddr = '0; WrBackData = '0; WrBackAddrVal = 1'b0;
    MemWrRdy = 1'b0; LookupAddr = '0; LookupEn = 1'b0;
    d1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    da = {$urandom(), $urandom(), $urandom(), $urandom()};
    db = {$urandom(), $urandom(), $urandom(), $urandom()};
    dc = {$urandom(), $urandom(), $urandom(), $urandom()};
    dd = {$urandom(), $urandom(), $urandom(), $urandom()};
    dx = {$urandom(), $urandom(), $urandom(), $urandom()};
    dy = {$urandom(), $urandom(), $urandom(), $urandom()};
    dn = {$urandom(), $urandom(), $urandom(), $urandom()};

    // Reset state
    repeat (3) step();
    check("rst_count", 192'(Count), 192'(0));
    check("rst_empty", 192'(Empty), 192'(1));
    check("rst_full", 192'(Full), 192'(0));
    check("rst_rdy", 192'(WrBackAddrRdy), 192'(0));
    check("rst_memval", 192'(MemWrVal), 192'(0));
    check("rst_memlast", 192'(MemWrLast), 192'(0));
    check("rst_memaddr", 192'(MemWrAddr), 192'(0));
    check("rst_memdata", 192'(MemWrData), 192'(0));
    check("rst_lkhit", 192'(LookupHit), 192'(0));
    check("rst_lkdata", 192'(LookupData), 192'(0));
    Rst = 1'b1;
    step();

    // Single line, bus always ready
    MemWrRdy = 1'b1;
    enq("t1_rdy", 32'h0000_1234, d1, 1'b1, 1'b1);
    wait_drain("t1_drain", 20);
    step(); step();
    check("t1_empty", 192'(Empty), 192'(1));
    check("t1_count", 192'(Count), 192'(0));
    check("t1_memval_idle", 192'(MemWrVal), 192'(0));

    // Fill while the bus stalls
    MemWrRdy = 1'b0;
    enq("t2_rdy0", 32'h0000_0100, da, 1'b1, 1'b1);
    enq("t2_rdy1", 32'h0000_0200, db, 1'b1, 1'b1);
    enq("t2_rdy2", 32'h0000_0300, dc, 1'b1, 1'b1);
    enq("t2_rdy3", 32'h0000_0400, dd, 1'b1, 1'b1);
    check("t2_full", 192'(Full), 192'(1));
    check("t2_count", 192'(Count), 192'(4));
    enq("t2_5th_rdy", 32'h0000_0500, dx, 1'b0, 1'b0);
    check("t2_5th_count", 192'(Count), 192'(4));
    check("t2_stall_val", 192'(MemWrVal), 192'(1));
    check("t2_stall_addr", 192'(MemWrAddr), 192'(32'h100));
    check("t2_stall_data", 192'(MemWrData), 192'(da[31:0]));
    step(); step();
    check("t2_hold_addr", 192'(MemWrAddr), 192'(32'h100));
    check("t2_hold_data", 192'(MemWrData), 192'(da[31:0]));
    check("t2_hold_last", 192'(MemWrLast), 192'(0));

    // Offer during the pop cycle of a full buffer
    MemWrRdy = 1'b1;
    step(); step(); step();
    WrBackAddr = 32'h0000_0600; WrBackData = dy; WrBackAddrVal = 1'b1;
    #1;
    check("t3_popcyc_rdy", 192'(WrBackAddrRdy), 192'(0));
    check("t3_popcyc_count", 192'(Count), 192'(4));
    check("t3_popcyc_last", 192'(MemWrLast), 192'(1));
    step();
    check("t3_after_pop_count", 192'(Count), 192'(3));
    check("t3_after_pop_rdy", 192'(WrBackAddrRdy), 192'(1));
    push_line(32'h0000_0600, dy);
    step();
    WrBackAddrVal = 1'b0;
    check("t3_refill_count", 192'(Count), 192'(4));
    wait_drain("t3_drain", 60);
    step(); step();
    check("t3_empty", 192'(Empty), 192'(1));

`ifndef WB_COALESCE_EN
    // Duplicate lines and lookup
    MemWrRdy = 1'b0;
    enq("t4_rdyA", 32'h0000_2000, da, 1'b1, 1'b1);
    enq("t4_rdyB", 32'h0000_2000, db, 1'b1, 1'b1);
    check("t4_count", 192'(Count), 192'(2));
    LookupEn = 1'b1; LookupAddr = 32'h0000_2008;
    step();
    check("t4_hit", 192'(LookupHit), 192'(1));
    check("t4_data_youngest", 192'(LookupData), 192'(db));
    LookupAddr = 32'h0000_3000;
    step();
    check("t4_miss", 192'(LookupHit), 192'(0));
    check("t4_miss_hold", 192'(LookupData), 192'(db));
    LookupAddr = 32'h0000_7004;
    enq("t4_rdyC", 32'h0000_7000, dc, 1'b1, 1'b1);
    check("t4_same_cycle_unseen", 192'(LookupHit), 192'(0));
    step();
    check("t4_next_cycle_hit", 192'(LookupHit), 192'(1));
    check("t4_next_cycle_data", 192'(LookupData), 192'(dc));
    LookupEn = 1'b0;
    step();
    check("t4_en_low", 192'(LookupHit), 192'(0));
    MemWrRdy = 1'b1;
    wait_drain("t4_drain", 60);
    step(); step();
`else
    // In-place coalescing into a non-head entry
    MemWrRdy = 1'b0;
    enq("t6_rdy_head", 32'h0000_4000, da, 1'b1, 1'b1);
    step();
    check("t6_bursting", 192'(MemWrVal), 192'(1));
    enq("t6_rdy_5000", 32'h0000_5000, db, 1'b1, 1'b0);
    enq("t6_rdy_coal", 32'h0000_5000, dn, 1'b1, 1'b1);
    check("t6_count", 192'(Count), 192'(2));
    MemWrRdy = 1'b1;
    wait_drain("t6_drain", 40);
    step(); step();
`endif

    // Reset in mid-burst
    MemWrRdy = 1'b1;
    enq("t5_rdy", 32'h0000_8000, dx, 1'b1, 1'b1);
    step(); step(); step();
    Rst = 1'b0;
    sb_q.delete();
    #1;
    check("t5_async_val", 192'(MemWrVal), 192'(0));
    check("t5_async_count", 192'(Count), 192'(0));
    step();
    check("t5_val", 192'(MemWrVal), 192'(0));
    check("t5_empty", 192'(Empty), 192'(1));
    Rst = 1'b1;
    repeat (5) step();
    check("t5_idle_val", 192'(MemWrVal), 192'(0));
    check("t5_idle_count", 192'(Count), 192'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
